switch_matrix_cfg: RTL
======================

Name: switch_matrix_cfg

Overview:
- Parametrised routing switch box for the FPGA fabric with four sides of bidirectional pins: top/bottom carry N_TB pins each, left/right carry N_LR pins each.
- Each pin is either undriven (Z) or driven from any pin on any side, selected by a per-pin route entry.
- Route entries are loaded at run time through a serial configuration chain into a shadow register, then committed atomically to the active register.
- On commit, every entry is sanitised so that illegal routes are forced off and flagged.

Parameters:
- N_TB, 5, pins on top and on bottom.
- N_LR, 4, pins on left and on right.
- IDX_W, 3, index field width; must satisfy 2**IDX_W >= max(N_TB,N_LR).
- ENT_W, derived = IDX_W+3, bits per route entry: {idx[IDX_W-1:0], side[2:0]}.
- N_PIN, derived = 2*N_TB+2*N_LR, total pins (default 18).
- CFG_BITS, derived = N_PIN*ENT_W, chain length (default 108).

Ports:
- clk  input  1  fabric configuration clock.
- rst_n  input  1  asynchronous active-low reset.
- wtop  inout  N_TB  top pins.
- wbottom  inout  N_TB  bottom pins.
- wleft  inout  N_LR  left pins.
- wright  inout  N_LR  right pins.
- cfg_en  input  1  shift enable; one bit is accepted per clk while high.
- cfg_in  input  1  serial configuration data.
- cfg_commit  input  1  single-cycle pulse that copies shadow to active.
- cfg_out  output  1  serial chain output (see Optional Feature).
- cfg_done  output  1  high when exactly CFG_BITS bits have been shifted since the last load start.
- cfg_err  output  1  sticky protocol error.
- cfg_bad  output  1  at least one entry was sanitised at the last commit.

Behaviour:
- Reset (async, rst_n=0):
  - shadow, active, bit counter = 0; FSM=IDLE.
  - cfg_done = 0, cfg_err = 0, cfg_bad = 0, cfg_out = 0.
  - All pins released (Z) immediately, not on the next clk edge.
- Side code: 0 = off, 1 = top, 2 = right, 3 = bottom, 4 = left; 5-7 are illegal.
- Pin drive (combinational from active register):
  - Pin = source pin[idx] on the selected side, else Z.
- Entry order in the chain: entry k covers
  - top[0..N_TB-1] for k = 0..N_TB-1,
  - then right[0..N_LR-1],
  - then bottom[0..N_TB-1],
  - then left[0..N_LR-1].
  - Entry k occupies shadow bits [k*ENT_W +: ENT_W].
- Shift:
  - On each clk with cfg_en=1: shadow <= {shadow[CFG_BITS-2:0], cfg_in}.
  - The first bit sent therefore ends up in shadow MSB, so the frame is sent MSB of left[N_LR-1] first.
  - Active routing is unchanged during shifting.
- FSM (the counter saturates at CFG_BITS):
  - IDLE: cfg_en=1 -> LOAD, count=1, cfg_err cleared.
  - LOAD: count increments per enabled bit. When count reaches CFG_BITS -> FULL, cfg_done=1. cfg_en low in LOAD holds the state (shifting pauses, no error).
  - FULL: cfg_commit=1 -> active <= sanitised shadow, cfg_bad updated, cfg_done=0, state IDLE. cfg_en=1 in FULL -> extra bit shifted, cfg_err=1, count stays saturated, state stays FULL.
  - cfg_commit in IDLE or LOAD -> ignored, active unchanged, cfg_err=1.
  - cfg_commit and cfg_en in the same cycle while in FULL -> cfg_err=1, no commit, bit shifted.
- Sanitise at commit: an entry is forced to 0 (off) when any of the following holds:
  - side > 4;
  - idx >= pin count of the selected side;
  - the entry selects its own pin (self loop).
  - cfg_bad = OR of all forced entries. Sanitised values are what the active register holds.
- Latency: the new routing is visible on the pins after the clk edge that samples cfg_commit=1.
- Indirect combinational loops (A<-B, B<-A) are not detected; preventing them is software's responsibility.
- Reset mid-load discards the partial frame and releases all pins.

Optional Feature:
- Macro CFG_READBACK_EN.
- Defined: cfg_out = shadow[CFG_BITS-1], combinational from the register, so chains of switch boxes can be daisy-chained. Shifting CFG_BITS more bits returns the previous frame in the order it was sent.
- Undefined: cfg_out is tied 0 and the readback path is not synthesised; all other behaviour is identical.

Test Plan:
- Reset then release -> all 18 pins Z; cfg_done, cfg_err, cfg_bad = 0.
- Shift 108 bits with top[2] = {idx 1, side 2} and all other entries 0, then commit -> drive wright[1]=1 and wtop[2]=1; drive wright[1]=0 and wtop[2]=0; every other pin stays Z; cfg_bad = 0.
- Frame with bottom[0] = {idx 6, side 1} (6 >= N_TB) and left[3] = {idx 3, side 4} (self loop), commit -> both pins Z, cfg_bad = 1.
- Commit after only 50 bits -> cfg_err = 1, previous routing still active. Then start a new load -> cfg_err clears on the first shifted bit.
- Full frame, then one extra cfg_en bit -> cfg_err = 1. rst_n pulsed low mid-load (bit 40) -> pins go Z asynchronously, FSM returns to IDLE.
- With CFG_READBACK_EN: load frame A, then shift frame B -> cfg_out reproduces frame A bit-for-bit over the 108 cycles. Without the macro -> cfg_out stays 0.

Source files
------------

// File: rtl/switch_matrix_cfg.sv
// switch_matrix_cfg: serially configured four-sided routing switch box; CFG_READBACK_EN drives cfg_out from the chain MSB
module switch_matrix_cfg #(
  parameter int N_TB  = 5,
  parameter int N_LR  = 4,
  parameter int IDX_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  inout  wire  [N_TB-1:0] wtop,
  inout  wire  [N_TB-1:0] wbottom,
  inout  wire  [N_LR-1:0] wleft,
  inout  wire  [N_LR-1:0] wright,
  input  logic            cfg_en,
  input  logic            cfg_in,
  input  logic            cfg_commit,
  output logic            cfg_out,
  output logic            cfg_done,
  output logic            cfg_err,
  output logic            cfg_bad
);
  localparam int ENT_W    = IDX_W + 3;
  localparam int N_PIN    = 2 * N_TB + 2 * N_LR;
  localparam int CFG_BITS = N_PIN * ENT_W;
  localparam int CW       = $clog2(CFG_BITS + 1);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, FULL = 2'd2;

  logic [1:0]          state;
  logic [CW-1:0]       cnt;
  logic [CFG_BITS-1:0] shadow, active, san;
  logic                err, bad, bad_any;
  logic [N_PIN-1:0]    pins, en, val;

  // flat pin view in chain order: top, right, bottom, left
  assign pins = {wleft, wbottom, wright, wtop};

  function automatic int side_base(input logic [2:0] s);
    return s == 3'd1 ? 0 : s == 3'd2 ? N_TB : s == 3'd3 ? N_TB + N_LR : 2 * N_TB + N_LR;
  endfunction

  function automatic int side_cnt(input logic [2:0] s);
    return (s == 3'd1 || s == 3'd3) ? N_TB : N_LR;
  endfunction

  function automatic logic illegal(input logic [ENT_W-1:0] e, input int k);
    logic [2:0] s;
    int x;
    s = e[2:0];
    x = int'(e[ENT_W-1:3]);
    return s > 3'd4 || (s != 3'd0 && (x >= side_cnt(s) || side_base(s) + x == k));
  endfunction

  // entries that route off-side, out of range or onto themselves are turned off
  always_comb begin
    san = '0;
    bad_any = 1'b0;
    for (int k = 0; k < N_PIN; k++) begin
      san[k*ENT_W +: ENT_W] = illegal(shadow[k*ENT_W +: ENT_W], k) ? '0 : shadow[k*ENT_W +: ENT_W];
      bad_any = bad_any | illegal(shadow[k*ENT_W +: ENT_W], k);
    end
  end

  // each pin with a non-off side copies its selected source pin
  always_comb begin
    en = '0;
    val = '0;
    for (int k = 0; k < N_PIN; k++) begin
      en[k] = active[k*ENT_W +: 3] != 3'd0;
      val[k] = en[k] ? pins[side_base(active[k*ENT_W +: 3]) + int'(active[k*ENT_W+3 +: IDX_W])] : 1'b0;
    end
  end

  for (genvar i = 0; i < N_TB; i++) begin : g_tb
    assign wtop[i]    = en[i] ? val[i] : 1'bz;
    assign wbottom[i] = en[N_TB+N_LR+i] ? val[N_TB+N_LR+i] : 1'bz;
  end

  for (genvar i = 0; i < N_LR; i++) begin : g_lr
    assign wright[i] = en[N_TB+i] ? val[N_TB+i] : 1'bz;
    assign wleft[i]  = en[2*N_TB+N_LR+i] ? val[2*N_TB+N_LR+i] : 1'bz;
  end

  // serial shadow chain, shifts on every enabled clock regardless of state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) shadow <= '0;
    else if (cfg_en) shadow <= {shadow[CFG_BITS-2:0], cfg_in};

  // load/commit sequencing with sticky protocol error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      active <= '0;
      err    <= 1'b0;
      bad    <= 1'b0;
    end else begin
      if (cfg_commit && state != FULL) err <= 1'b1;
      if (state == IDLE && cfg_en) begin
        state <= LOAD;
        cnt   <= CW'(1);
        err   <= cfg_commit;
      end else if (state == LOAD && cfg_en) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(CFG_BITS - 1)) state <= FULL;
      end else if (state == FULL && cfg_en) begin
        err <= 1'b1;
      end else if (state == FULL && cfg_commit) begin
        active <= san;
        bad    <= bad_any;
        state  <= IDLE;
        cnt    <= '0;
      end
    end
  end

  assign cfg_done = state == FULL;
  assign cfg_err  = err;
  assign cfg_bad  = bad;
`ifdef CFG_READBACK_EN
  assign cfg_out = shadow[CFG_BITS-1];
`else
  assign cfg_out = 1'b0;
`endif
endmodule
